assert_monitor: RTL and testbench

ASSERT_MONITOR -- requirements
Module: assert_monitor

---
 rtl/assert_monitor_pkg.sv | 18 +
 rtl/assert_monitor_ch.sv | 80 ++++++++
 rtl/assert_monitor.sv | 98 +++++++++
 tb/tb_assert_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/assert_monitor_pkg.sv
// Shared types for the assertion monitor: per-channel check mode and the
// windowed-check channel state.
package assert_monitor_pkg;

    typedef enum logic {
        MODE_IMM = 1'b0,
        MODE_WIN = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ch_state_e;

    // Popcount of up to 32 simultaneous failures fits in 6 bits.
    localparam int POP_W = 6;

endpackage

// File: rtl/assert_monitor_ch.sv
// One check channel: same-cycle implication (IMM) or windowed implication (WIN)
// with a bounded response latency. Emits a combinational failure detect.
module assert_monitor_ch
    import assert_monitor_pkg::*;
#(
    parameter int MAX_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic mode,
    input  logic ante,
    input  logic cons,
    output logic fail
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    ch_state_e        state;
    ch_state_e        state_nx;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_cnt_nx;
    mode_e            mode_s;
    logic             arm_req;

    assign mode_s  = mode_e'(mode);
    assign arm_req = en && ante && (mode_s == MODE_WIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_cnt_nx;
        end
    end

    // A window closes on cons or on its last cycle; either closing edge may
    // immediately open a new window so back-to-back requests are not lost.
    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        fail       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm_req) begin
                    state_nx   = ST_WAIT;
                    lat_cnt_nx = LAT_ONE;
                end else if (en && ante && !cons && (mode_s == MODE_IMM)) begin
                    fail = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    state_nx   = ST_IDLE;
                    lat_cnt_nx = '0;
                end else if (cons || (lat_cnt == LAT_END)) begin
                    fail = !cons;
                    if (arm_req) begin
                        state_nx   = ST_WAIT;
                        lat_cnt_nx = LAT_ONE;
                    end else begin
                        state_nx   = ST_IDLE;
                        lat_cnt_nx = '0;
                    end
                end else begin
                    lat_cnt_nx = lat_cnt + LAT_ONE;
                end
            end
            default: begin
                state_nx   = ST_IDLE;
                lat_cnt_nx = '0;
            end
        endcase
    end

endmodule

// File: rtl/assert_monitor.sv
// Multi-channel assertion monitor: per-channel checkers plus registered
// failure strobes, sticky flags, saturating count and first-failure capture.
module assert_monitor
    import assert_monitor_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MAX_LAT = 8,
    parameter int CNT_W   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CH-1:0]                       en,
    input  logic [N_CH-1:0]                       mode,
    input  logic [N_CH-1:0]                       ante,
    input  logic [N_CH-1:0]                       cons,
    input  logic                                  clr,
    output logic [N_CH-1:0]                       fail_pulse,
    output logic [N_CH-1:0]                       fail_sticky,
    output logic [CNT_W-1:0]                      fail_cnt,
    output logic                                  first_valid,
    output logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0] first_ch
);

    localparam int CH_W  = $clog2(N_CH > 1 ? N_CH : 2);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX_W = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

    logic [N_CH-1:0]  fail_det;
    logic [POP_W-1:0] pop;
    logic [CH_W-1:0]  first_idx;
    logic [N_CH-1:0]  sticky_base;
    logic [CNT_W-1:0] cnt_base;
    logic             fv_base;
    logic [CH_W-1:0]  fch_base;
    logic [SUM_W-1:0] sum_wide;
    logic [CNT_W-1:0] cnt_nx;
    logic             fv_nx;
    logic [CH_W-1:0]  fch_nx;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assert_monitor_ch #(
            .MAX_LAT(MAX_LAT)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .en  (en[i]),
            .mode(mode[i]),
            .ante(ante[i]),
            .cons(cons[i]),
            .fail(fail_det[i])
        );
    end

    always_comb begin
        pop       = '0;
        first_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            pop = pop + POP_W'(fail_det[i]);
            if (fail_det[i]) begin
                first_idx = CH_W'(i);
            end
        end
    end

    // clr wipes the recorded history first, so failures on the same edge
    // land on a clean slate rather than being lost.
    always_comb begin
        sticky_base = clr ? '0 : fail_sticky;
        cnt_base    = clr ? '0 : fail_cnt;
        fv_base     = clr ? 1'b0 : first_valid;
        fch_base    = clr ? '0 : first_ch;
        sum_wide    = SUM_W'(cnt_base) + SUM_W'(pop);
        cnt_nx      = (sum_wide > CNT_MAX_W) ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
        fv_nx       = fv_base;
        fch_nx      = fch_base;
        if (!fv_base && (|fail_det)) begin
            fv_nx  = 1'b1;
            fch_nx = first_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_pulse  <= '0;
            fail_sticky <= '0;
            fail_cnt    <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else begin
            fail_pulse  <= fail_det;
            fail_sticky <= sticky_base | fail_det;
            fail_cnt    <= cnt_nx;
            first_valid <= fv_nx;
            first_ch    <= fch_nx;
        end
    end

endmodule

// File: tb/tb_assert_monitor.sv
// Directed scoreboard bench for assert_monitor: a 16-bit counter instance and a
// 2-bit counter instance share stimulus so saturation is observed alongside.
module tb_assert_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en, mode, ante, cons;
    logic       clr;

    logic [3:0]  fail_pulse, fail_sticky;
    logic [15:0] fail_cnt;
    logic        first_valid;
    logic [1:0]  first_ch;

    logic [3:0] sat_pulse, sat_sticky;
    logic [1:0] sat_cnt;
    logic       sat_valid;
    logic [1:0] sat_ch;

    typedef struct {
        logic [3:0]  pulse;
        logic [3:0]  sticky;
        logic [15:0] cnt;
        logic [1:0]  sat;
        logic        fv;
        logic [1:0]  fch;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] m_sticky;
    int         m_cnt;
    int         m_sat;
    logic       m_fv;
    logic [1:0] m_fch;

    localparam logic [3:0] E1 = 4'b0010;
    localparam logic [3:0] M1 = 4'b0010;

    always #5 clk = ~clk;

    assert_monitor #(.N_CH(4), .MAX_LAT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ante(ante), .cons(cons),
        .clr(clr), .fail_pulse(fail_pulse), .fail_sticky(fail_sticky),
        .fail_cnt(fail_cnt), .first_valid(first_valid), .first_ch(first_ch)
    );

    assert_monitor #(.N_CH(4), .MAX_LAT(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ante(ante), .cons(cons),
        .clr(clr), .fail_pulse(sat_pulse), .fail_sticky(sat_sticky),
        .fail_cnt(sat_cnt), .first_valid(sat_valid), .first_ch(sat_ch)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        assert (act === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Expected aggregate behaviour: clear first, then record this edge's failures.
    task automatic pushExpected(input logic [3:0] pulse, input logic clear, input string tag);
        exp_t e;
        if (clear) begin
            m_sticky = '0; m_cnt = 0; m_sat = 0; m_fv = 1'b0; m_fch = '0;
        end
        m_sticky = m_sticky | pulse;
        m_cnt    = m_cnt + $countones(pulse);
        if (m_cnt > 65535) m_cnt = 65535;
        m_sat    = m_sat + $countones(pulse);
        if (m_sat > 3) m_sat = 3;
        if (!m_fv && pulse != 4'b0000) begin
            m_fv = 1'b1;
            for (int i = 3; i >= 0; i--) if (pulse[i]) m_fch = 2'(i);
        end
        e.pulse = pulse; e.sticky = m_sticky; e.cnt = 16'(m_cnt); e.sat = 2'(m_sat);
        e.fv = m_fv; e.fch = m_fch; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty observed=empty expected=entry");
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".pulse"},   32'(fail_pulse),  32'(e.pulse));
        chk({e.tag, ".sticky"},  32'(fail_sticky), 32'(e.sticky));
        chk({e.tag, ".cnt"},     32'(fail_cnt),    32'(e.cnt));
        chk({e.tag, ".valid"},   32'(first_valid), 32'(e.fv));
        chk({e.tag, ".first"},   32'(first_ch),    32'(e.fch));
        chk({e.tag, ".sat_cnt"}, 32'(sat_cnt),     32'(e.sat));
    endtask

    task automatic applyStimulus(input logic [3:0] e_in, input logic [3:0] m_in,
                                 input logic [3:0] a_in, input logic [3:0] c_in,
                                 input logic clr_in, input logic [3:0] exp_pulse,
                                 input string tag);
        @(negedge clk);
        rst = 1'b0; en = e_in; mode = m_in; ante = a_in; cons = c_in; clr = clr_in;
        pushExpected(exp_pulse, clr_in, tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        rst = 1'b1; en = '0; mode = '0; ante = '0; cons = '0; clr = 1'b0;
        pushExpected(4'b0000, 1'b1, tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic winWait(input int n, input logic [3:0] e_in, input string tag);
        repeat (n) applyStimulus(e_in, M1, 4'b0000, 4'b0000, 1'b0, 4'b0000, tag);
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0; ante = '0; cons = '0; clr = 1'b0;
        m_sticky = '0; m_cnt = 0; m_sat = 0; m_fv = 1'b0; m_fch = '0;

        applyReset("reset0");
        applyReset("reset1");

        // Same-cycle implication
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0001, "imm_fail");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, "imm_pulse_end");
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 4'b0000, "imm_pass");
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0000, "imm_disabled");

        // Window satisfied on its last cycle
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "win_arm");
        winWait(7, E1, "win_wait");
        applyStimulus(E1, M1, 4'b0000, 4'b0010, 1'b0, 4'b0000, "win_pass");
        winWait(10, E1, "win_after_pass");

        // Window expires; extra ante and a mode change mid-window are ignored
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "win_arm2");
        winWait(3, E1, "win_wait2");
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "win_ante_ignored");
        applyStimulus(E1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, "win_mode_change");
        winWait(2, E1, "win_wait2b");
        applyStimulus(E1, M1, 4'b0000, 4'b0000, 1'b0, 4'b0010, "win_timeout");
        applyStimulus(E1, M1, 4'b0000, 4'b0000, 1'b0, 4'b0000, "win_pulse_end");

        // Re-arm at the failure edge, then let the new window expire too
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "rearm_arm");
        winWait(7, E1, "rearm_wait");
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0010, "rearm_fail1");
        winWait(7, E1, "rearm_wait2");
        applyStimulus(E1, M1, 4'b0000, 4'b0000, 1'b0, 4'b0010, "rearm_fail2");

        // Re-arm at the failure edge, satisfied on the next edge
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "rearm2_arm");
        winWait(7, E1, "rearm2_wait");
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0010, "rearm2_fail");
        applyStimulus(E1, M1, 4'b0000, 4'b0010, 1'b0, 4'b0000, "rearm2_pass");
        winWait(10, E1, "rearm2_after");

        // Earliest possible response
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "early_arm");
        applyStimulus(E1, M1, 4'b0000, 4'b0010, 1'b0, 4'b0000, "early_pass");
        winWait(10, E1, "early_after");

        // Enable dropped at t0+3 discards the window
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "endrop_arm");
        winWait(2, E1, "endrop_wait");
        applyStimulus(4'b0000, M1, 4'b0000, 4'b0000, 1'b0, 4'b0000, "endrop_edge");
        winWait(10, E1, "endrop_after");

        // Simultaneous failures, priority capture, 2-bit saturation
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, "clr1");
        applyStimulus(4'b1100, 4'b0000, 4'b1100, 4'b0000, 1'b0, 4'b1100, "simul_2_3");
        applyStimulus(4'b0111, 4'b0000, 4'b0111, 4'b0000, 1'b0, 4'b0111, "simul_0_1_2");

        // clr on the same edge as a failure
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, "clr2");
        applyStimulus(4'b1110, 4'b0000, 4'b1110, 4'b0000, 1'b0, 4'b1110, "pre_clr_a");
        applyStimulus(4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b1000, "pre_clr_b");
        applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0001, "clr_with_fail");

        // Reset at t0+3 discards the window
        applyStimulus(E1, M1, 4'b0010, 4'b0000, 1'b0, 4'b0000, "rst_arm");
        winWait(2, E1, "rst_wait");
        applyReset("rst_mid_window");
        winWait(10, E1, "rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
